// File: rtl/mux_8_1_v_behavior.sv
// ---------------------------------------------------------------------------
// mux_8_1_v_behavior
//   Behavioural 8-to-1 single-bit multiplexer with an active-high enable and
//   a registered output. One bit of i_code is picked by i_sel_code, gated by
//   i_en, and presented on o_f one clock later.
//
// Ports
//   i_clk       in   1  system clock, rising edge
//   i_n_rst     in   1  synchronous active-low reset
//   i_en        in   1  active-high enable, 0 forces the next o_f low
//   i_code      in   8  data inputs, bit k chosen when i_sel_code == k
//   i_sel_code  in   3  binary select code, bit 2 = MSB
//   o_f         out  1  registered mux output
// ---------------------------------------------------------------------------
module mux_8_1_v_behavior (
  input  logic       i_clk,
  input  logic       i_n_rst,
  input  logic       i_en,
  input  logic [7:0] i_code,
  input  logic [2:0] i_sel_code,
  output logic       o_f
);

  logic w_f_next;
  logic r_f;

  // All 8 select codes are legal, so a plain index covers the full decode.
  always_comb begin
    w_f_next = 1'b0;
    if (i_en) w_f_next = i_code[i_sel_code];
  end

  // The flop clocks every cycle; enable only shapes the value it captures.
  always_ff @(posedge i_clk) begin
    if (!i_n_rst) r_f <= 1'b0;
    else          r_f <= w_f_next;
  end

  assign o_f = r_f;

endmodule

// File: tb/tb_mux_8_1_v_behavior.sv
module tb_mux_8_1_v_behavior;

  logic       clk;
  logic       n_rst;
  logic       en;
  logic [7:0] code;
  logic [2:0] sel;
  logic       f;

  typedef struct {
    logic  exp;
    string name;
  } exp_t;

  exp_t q[$];
  int   tests;
  int   fails;
  logic stim_done;

  mux_8_1_v_behavior dut (
    .i_clk      (clk),
    .i_n_rst    (n_rst),
    .i_en       (en),
    .i_code     (code),
    .i_sel_code (sel),
    .o_f        (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one vector on the falling edge; its response is due after the
  // following rising edge, so the expectation is queued here.
  task automatic apply(input logic r, input logic e, input logic [7:0] c,
                       input logic [2:0] s, input logic exp, input string nm);
    exp_t t;
    @(negedge clk);
    n_rst = r; en = e; code = c; sel = s;
    t.exp = exp; t.name = nm;
    q.push_back(t);
  endtask

  // Monitor: one expected value consumed per rising edge.
  always @(posedge clk) begin
    exp_t t;
    #1;
    if (q.size() > 0) begin
      t = q.pop_front();
      tests++;
      if (f !== t.exp) begin
        fails++;
        $display("FAIL %s: o_f=%b expected %b", t.name, f, t.exp);
      end
    end
  end

  initial begin
    logic [11:0] v;
    logic [7:0]  cw;
    logic        ex;
    tests = 0; fails = 0; stim_done = 1'b0;
    n_rst = 1'b0; en = 1'b1; code = 8'hFF; sel = 3'd5;

    // Reset with inputs that would otherwise produce 1.
    apply(1'b0, 1'b1, 8'hFF, 3'd5, 1'b0, "reset0");
    apply(1'b0, 1'b1, 8'hFF, 3'd5, 1'b0, "reset1");
    apply(1'b1, 1'b1, 8'hFF, 3'd5, 1'b1, "reset_release");

    // Reset asserted mid-cycle must not affect o_f before the edge.
    @(negedge clk);
    n_rst = 1'b0;
    #2;
    tests++;
    if (f !== 1'b1) begin
      fails++;
      $display("FAIL sync_reset_between_edges: o_f=%b expected 1", f);
    end
    begin
      exp_t t;
      t.exp = 1'b0; t.name = "sync_reset_at_edge";
      q.push_back(t);
    end

    // Walking one on bit 3.
    apply(1'b1, 1'b1, 8'b0000_1000, 3'd0, 1'b0, "walk1_sel0");
    apply(1'b1, 1'b1, 8'b0000_1000, 3'd1, 1'b0, "walk1_sel1");
    apply(1'b1, 1'b1, 8'b0000_1000, 3'd2, 1'b0, "walk1_sel2");
    apply(1'b1, 1'b1, 8'b0000_1000, 3'd3, 1'b1, "walk1_sel3");
    apply(1'b1, 1'b1, 8'b0000_1000, 3'd4, 1'b0, "walk1_sel4");
    apply(1'b1, 1'b1, 8'b0000_1000, 3'd5, 1'b0, "walk1_sel5");
    apply(1'b1, 1'b1, 8'b0000_1000, 3'd6, 1'b0, "walk1_sel6");
    apply(1'b1, 1'b1, 8'b0000_1000, 3'd7, 1'b0, "walk1_sel7");

    // Enable gating.
    apply(1'b1, 1'b0, 8'hFF, 3'd7, 1'b0, "en_low");
    apply(1'b1, 1'b1, 8'hFF, 3'd7, 1'b1, "en_high");
    apply(1'b1, 1'b0, 8'hFF, 3'd0, 1'b0, "en_low_sel0");

    // Walking zero on bit 6.
    apply(1'b1, 1'b1, 8'b1011_1111, 3'd6, 1'b0, "walk0_sel6");
    apply(1'b1, 1'b1, 8'b1011_1111, 3'd7, 1'b1, "walk0_sel7");

    // Exhaustive {en, sel, code} sweep with one reset cycle spliced in.
    for (int i = 0; i < 4096; i++) begin
      if (i == 2000) begin
        apply(1'b0, 1'b1, 8'hFF, 3'd2, 1'b0, "sweep_mid_reset");
        apply(1'b1, 1'b1, 8'hFF, 3'd2, 1'b1, "sweep_after_reset");
      end
      v  = 12'(i);
      cw = v[7:0];
      ex = v[11] & cw[v[10:8]];
      apply(1'b1, v[11], cw, v[10:8], ex, $sformatf("sweep_%0d", i));
    end

    // Let the monitor drain; anything left over is a lost response.
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
    end
    stim_done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop in case the stimulus process ever stalls.
  initial begin
    #500000;
    if (!stim_done) begin
      $display("FAIL timeout: stimulus incomplete, expected completion");
      $fatal(1, "timeout");
    end
  end

endmodule
